// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding and Booth recoding pair codes {Q[0], q_1}.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Start/done request bus of the sequential Booth multiplier.
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 8
);

  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       x;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     p;

  modport master (
    output start, signed_mode, a, x,
    input  busy, done, p
  );

  modport slave (
    input  start, signed_mode, a, x,
    output busy, done, p
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,q_1}. A carries one guard bit above M.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] a_i,
  input  logic [WIDTH:0]   q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH+1:0] a_o,
  output logic [WIDTH:0]   q_o,
  output logic             q1_o
);

  logic [WIDTH+1:0] m_ext_s;
  logic [WIDTH+1:0] sum_s;

  assign m_ext_s = {m_i[WIDTH], m_i};

  // Booth recoding of the current multiplier pair
  always_comb begin
    sum_s = a_i;
    case ({q_i[0], q1_i})
      BOOTH_ADD:  sum_s = a_i + m_ext_s;
      BOOTH_SUB:  sum_s = a_i - m_ext_s;
      BOOTH_NOP0: sum_s = a_i;
      BOOTH_NOP1: sum_s = a_i;
      default:    sum_s = a_i;
    endcase
  end

  assign a_o  = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
  assign q_o  = {sum_s[0], q_i[WIDTH:1]};
  assign q1_o = q_i[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one recoding step per clock.
// Operands are widened by one bit so signed and unsigned share one datapath.
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_multiplier_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH+1:0]     acc_q, acc_d;
  logic [WIDTH:0]       q_q, q_d;
  logic                 q1_q, q1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 load_s;
  logic [WIDTH:0]       a_ext_s;
  logic [WIDTH:0]       x_ext_s;
  logic [WIDTH+1:0]     acc_s;
  logic [WIDTH:0]       q_s;
  logic                 q1_s;

  assign a_ext_s = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
  assign x_ext_s = {bus.signed_mode & bus.x[WIDTH-1], bus.x};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i  (acc_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (acc_s),
    .q_o  (q_s),
    .q1_o (q1_s)
  );

  // Next-state, datapath update and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    p_d     = p_q;
    load_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_s;
        q_d   = q_s;
        q1_d  = q1_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH)) begin
          p_d     = {acc_s[WIDTH-2:0], q_s};
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      m_d   = a_ext_s;
      q_d   = x_ext_s;
      q1_d  = 1'b0;
      acc_d = '0;
      cnt_d = '0;
    end else begin
      m_d   = m_d;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench: vector table, multi-cycle corner sequences and random
// operations on WIDTH=8 and WIDTH=16 instances, with a result scoreboard.
module tb_booth_multiplier_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  booth_multiplier_seq_if #(.WIDTH(8))  if8 ();
  booth_multiplier_seq_if #(.WIDTH(16)) if16 ();

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  booth_multiplier_seq #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q8[$];
  logic [31:0] exp_q16[$];

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] x);
    logic signed [15:0] sa;
    logic signed [15:0] sx;
    if (sm) begin
      sa = $signed(a);
      sx = $signed(x);
      return sa * sx;
    end
    return {8'd0, a} * {8'd0, x};
  endfunction

  function automatic logic [31:0] model16(input logic sm, input logic [15:0] a, input logic [15:0] x);
    logic signed [31:0] sa;
    logic signed [31:0] sx;
    if (sm) begin
      sa = $signed(a);
      sx = $signed(x);
      return sa * sx;
    end
    return {16'd0, a} * {16'd0, x};
  endfunction

  // Monitor: exclusivity, scoreboard on done, p stability otherwise
  initial begin
    logic [15:0] prev8;
    logic [31:0] prev16;
    prev8  = 16'd0;
    prev16 = 32'd0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        check("excl8", {31'd0, if8.busy & if8.done}, 32'd0);
        check("excl16", {31'd0, if16.busy & if16.done}, 32'd0);
        if (if8.done) begin
          if (exp_q8.size() == 0) check("sb8_empty", 32'd1, 32'd0);
          else check("sb8_p", {16'd0, if8.p}, {16'd0, exp_q8.pop_front()});
        end else begin
          check("p8_stable", {16'd0, if8.p}, {16'd0, prev8});
        end
        if (if16.done) begin
          if (exp_q16.size() == 0) check("sb16_empty", 32'd1, 32'd0);
          else check("sb16_p", if16.p, exp_q16.pop_front());
        end else begin
          check("p16_stable", if16.p, prev16);
        end
      end
      prev8  = if8.p;
      prev16 = if16.p;
    end
  end

  task automatic wait_done8(input int exp_lat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (if8.done) seen = 1'b1;
      else check("busy8_run", {31'd0, if8.busy}, 32'd1);
    end
    if (!seen) check("timeout8", 32'd0, 32'd1);
    else check("latency8", lat, exp_lat);
  endtask

  task automatic wait_done16(input int exp_lat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (if16.done) seen = 1'b1;
      else check("busy16_run", {31'd0, if16.busy}, 32'd1);
    end
    if (!seen) check("timeout16", 32'd0, 32'd1);
    else check("latency16", lat, exp_lat);
  endtask

  task automatic run_op8(input logic sm, input logic [7:0] a, input logic [7:0] x);
    if8.signed_mode = sm;
    if8.a           = a;
    if8.x           = x;
    if8.start       = 1'b1;
    exp_q8.push_back(model8(sm, a, x));
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    wait_done8(9);
  endtask

  task automatic run_op16(input logic sm, input logic [15:0] a, input logic [15:0] x);
    if16.signed_mode = sm;
    if16.a           = a;
    if16.x           = x;
    if16.start       = 1'b1;
    exp_q16.push_back(model16(sm, a, x));
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    wait_done16(17);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h07, 8'hFD, 16'hFFEB};
    vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[3]  = '{1'b1, 8'h00, 8'h5A, 16'h0000};
    vecs[4]  = '{1'b0, 8'hA5, 8'h00, 16'h0000};
    vecs[5]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[8]  = '{1'b0, 8'hC8, 8'h03, 16'h0258};
    vecs[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[10] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[11] = '{1'b0, 8'h01, 8'hFF, 16'h00FF};

    rst              = 1'b1;
    if8.start        = 1'b0;
    if8.signed_mode  = 1'b0;
    if8.a            = 8'd0;
    if8.x            = 8'd0;
    if16.start       = 1'b0;
    if16.signed_mode = 1'b0;
    if16.a           = 16'd0;
    if16.x           = 16'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, if8.busy}, 32'd0);
    check("rst_done", {31'd0, if8.done}, 32'd0);
    check("rst_p", {16'd0, if8.p}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op8(vecs[i].sm, vecs[i].a, vecs[i].x);
      check("vec_p", {16'd0, if8.p}, {16'd0, vecs[i].exp});
    end

    // Start pulsed mid-RUN with different operands and mode
    @(posedge clk);
    #1;
    if8.signed_mode = 1'b1;
    if8.a           = 8'h07;
    if8.x           = 8'hFD;
    if8.start       = 1'b1;
    exp_q8.push_back(16'hFFEB);
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("mid_busy", {31'd0, if8.busy}, 32'd1);
    end
    if8.signed_mode = 1'b0;
    if8.a           = 8'd55;
    if8.x           = 8'd99;
    if8.start       = 1'b1;
    @(posedge clk);
    #1;
    check("mid_busy_pulse", {31'd0, if8.busy}, 32'd1);
    if8.start = 1'b0;
    wait_done8(5);
    check("mid_p", {16'd0, if8.p}, 32'h0000FFEB);
    @(posedge clk);
    #1;
    check("mid_idle_busy", {31'd0, if8.busy}, 32'd0);
    check("mid_idle_done", {31'd0, if8.done}, 32'd0);

    // Start held through DONE: back-to-back second operation
    if8.signed_mode = 1'b1;
    if8.a           = 8'h07;
    if8.x           = 8'hFD;
    if8.start       = 1'b1;
    exp_q8.push_back(16'hFFEB);
    @(posedge clk);
    #1;
    wait_done8(9);
    if8.signed_mode = 1'b0;
    if8.a           = 8'hFF;
    if8.x           = 8'hFF;
    exp_q8.push_back(16'hFE01);
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    check("b2b_busy", {31'd0, if8.busy}, 32'd1);
    check("b2b_held_p", {16'd0, if8.p}, 32'h0000FFEB);
    wait_done8(9);
    check("b2b_p", {16'd0, if8.p}, 32'h0000FE01);

    // Asynchronous reset during step 4 of RUN
    if8.signed_mode = 1'b1;
    if8.a           = 8'd100;
    if8.x           = 8'd3;
    if8.start       = 1'b1;
    exp_q8.push_back(16'd300);
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, if8.busy}, 32'd0);
    check("arst_done", {31'd0, if8.done}, 32'd0);
    check("arst_p", {16'd0, if8.p}, 32'd0);
    void'(exp_q8.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst_idle_p", {16'd0, if8.p}, 32'd0);
    run_op8(1'b1, 8'hFB, 8'h09);
    check("arst_clean_p", {16'd0, if8.p}, 32'h0000FFD3);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op8(m[0], 8'($urandom), 8'($urandom));
      end
    end
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op16(m[0], 16'($urandom), 16'($urandom));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb8_drained", exp_q8.size(), 32'd0);
    check("sb16_drained", exp_q16.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
